br_send_arbiter: RTL and testbench
==================================

# br_send_arbiter

Round-robin arbiter sharing the single BrLite local output port of the DMNI among `N_REQ` internal requesters, such as kernel-service MMR writes and monitoring publishers. It latches the winner's payload, drives the BrLite req/ack handshake and returns a one-cycle completion pulse to the winner. An optional watchdog abandons a send whose ack never arrives. It sits between the NI-side requesters and the BrLite router local input.

## Interface
- `N_REQ`, default 2: number of requesters, ≥2.
- `ACK_TIMEOUT`, default 0: cycles to wait for `br_ack_i` in SEND; 0 disables the watchdog.

- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  N_REQ  per-requester send request; level, held until own `ack_o` bit.
- `data_i`  in  N_REQ × br_payload_t  per-requester payload; stable while `req_i` bit high.
- `ack_o`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `drop_o`  out  1  one-cycle pulse with `ack_o` when the send was aborted by timeout.
- `grant_o`  out  $clog2(N_REQ)  index of current/last granted requester.
- `busy_o`  out  1  high while state ≠ IDLE.
- `sent_cnt_o`  out  32  count of acked sends; wraps at 2^32.
- `br_local_busy_i`  in  1  BrLite local port busy; no new grant while high.
- `br_req_o`  out  1  BrLite send request.
- `br_ack_i`  in  1  BrLite accept.
- `br_data_o`  out  br_payload_t  latched payload of the granted requester.

## Operation
- FSM states: IDLE, SEND, RELEASE. All outputs are registered.
- IDLE: if any `req_i` bit is set and `!br_local_busy_i`, select the first set bit searching from `rr_ptr` upward with modulo `N_REQ` wrap. Then:
  - `grant_o` ← g, `br_data_o` ← `data_i[g]`, `br_req_o` ← 1, timeout counter ← 0.
  - Next state: SEND.
- SEND: `br_req_o` and `br_data_o` are held.
  - If `br_ack_i`: `br_req_o` ← 0, `ack_o[g]` ← 1, `sent_cnt_o` += 1, `rr_ptr` ← (g+1) mod N_REQ. Next state: RELEASE.
  - Else if `ACK_TIMEOUT` ≠ 0 and counter == `ACK_TIMEOUT`−1: `br_req_o` ← 0, `ack_o[g]` ← 1, `drop_o` ← 1, `rr_ptr` ← (g+1) mod N_REQ, `sent_cnt_o` unchanged. Next state: RELEASE.
  - Else the counter increments. Counter width is $clog2(ACK_TIMEOUT+1); it saturates and is never used when `ACK_TIMEOUT` = 0.
- RELEASE: `ack_o` ← 0, `drop_o` ← 0. Next state: IDLE.
  - This state gives the requester one cycle to drop `req_i`, so a level request is never re-granted twice.
- A requester that deasserts `req_i` after being granted does not cancel the transfer; it still receives `ack_o`.
- `req_i` bits that change in SEND or RELEASE are only sampled in IDLE.
- Simultaneous `br_ack_i` and timeout expiry: the ack wins, and `drop_o` stays 0.
- `br_ack_i` outside SEND is ignored.

## Timing
- Reset values: `br_req_o`=0, `br_data_o`='0, `ack_o`='0, `drop_o`=0, `grant_o`=0, `busy_o`=0, `sent_cnt_o`=0, `rr_ptr`=0, state IDLE.
- Reset asserted mid-SEND drops `br_req_o` on that edge. No `ack_o` is issued for the aborted send.
- Request to bus latency: a request visible in IDLE at edge t gives `br_req_o`=1 and valid `br_data_o` after edge t.
- Ack to completion: `br_ack_i` sampled at edge k gives `br_req_o`=0 and `ack_o[g]`=1 during cycle k..k+1.
  - The FSM is back in IDLE after edge k+1.
  - The earliest next `br_req_o` is after edge k+2.
  - Minimum spacing between consecutive sends is 3 cycles.
- Timeout: with no ack, `br_req_o` is high for exactly `ACK_TIMEOUT` cycles.
- `busy_o` is high from the edge that enters SEND until the edge that returns to IDLE.

## Test plan
- Single send: `req_i`=01, `data_i[0]`.ksvc=4'h5, ack 2 cycles after `br_req_o` rises -> `br_data_o`.ksvc=5, `ack_o`=01 for one cycle, `sent_cnt_o`=1, `busy_o` high for 4 cycles.
- Fairness: both requesters held continuously, immediate ack each time -> grant sequence 0,1,0,1, with `br_req_o` rising every 3 cycles.
- Busy gating: `br_local_busy_i`=1 for 10 cycles with `req_i`=10 -> `br_req_o` stays 0; it rises 1 cycle after busy drops, with `grant_o`=1.
- Timeout: `ACK_TIMEOUT`=8, no ack -> `br_req_o` high exactly 8 cycles; `ack_o[g]` and `drop_o` pulse together; `sent_cnt_o` unchanged; the other requester is granted next.
- Ack at timeout edge: `ACK_TIMEOUT`=4, ack on the 4th SEND cycle -> `drop_o`=0 and `sent_cnt_o` increments.
- Reset mid-SEND: `rst_i` pulsed while `br_req_o`=1 -> all outputs at reset values next cycle; the still-held request is re-granted starting from index 0.

Source files
------------

// File: rtl/br_send_arbiter.sv
// Round-robin arbiter sharing the BrLite local output among N_REQ requesters,
// with a registered req/ack handshake, per-requester completion pulse and optional ack watchdog.
module br_send_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ACK_TIMEOUT = 0,
    parameter int PAYLOAD_W   = 64,
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_REQ-1:0]                req_i,
    input  logic [N_REQ-1:0][PAYLOAD_W-1:0] data_i,
    output logic [N_REQ-1:0]                ack_o,
    output logic                            drop_o,
    output logic [GW-1:0]                   grant_o,
    output logic                            busy_o,
    output logic [31:0]                     sent_cnt_o,
    input  logic                            br_local_busy_i,
    output logic                            br_req_o,
    input  logic                            br_ack_i,
    output logic [PAYLOAD_W-1:0]            br_data_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [TW-1:0] TMO_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t               state_q;
    logic                 br_req_q;
    logic [PAYLOAD_W-1:0] br_data_q;
    logic [N_REQ-1:0]     ack_q;
    logic                 drop_q;
    logic [GW-1:0]        grant_q;
    logic                 busy_q;
    logic [31:0]          sent_cnt_q;
    logic [GW-1:0]        rr_ptr_q;
    logic [TW-1:0]        tmo_cnt_q;

    logic                 found;
    logic [GW-1:0]        sel;
    logic [GW-1:0]        ptr_d;
    logic                 timeout_hit;

    // First requesting index at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end
    end

    assign ptr_d       = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign timeout_hit = (ACK_TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            br_req_q   <= 1'b0;
            br_data_q  <= '0;
            ack_q      <= '0;
            drop_q     <= 1'b0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            sent_cnt_q <= '0;
            rr_ptr_q   <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found && !br_local_busy_i) begin
                        grant_q   <= sel;
                        br_data_q <= data_i[sel];
                        br_req_q  <= 1'b1;
                        tmo_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    // Ack takes priority over a watchdog expiry on the same edge.
                    if (br_ack_i) begin
                        br_req_q   <= 1'b0;
                        ack_q      <= ONE_HOT0 << grant_q;
                        sent_cnt_q <= sent_cnt_q + 32'd1;
                        rr_ptr_q   <= ptr_d;
                        state_q    <= RELEASE;
                    end else if (timeout_hit) begin
                        br_req_q <= 1'b0;
                        ack_q    <= ONE_HOT0 << grant_q;
                        drop_q   <= 1'b1;
                        rr_ptr_q <= ptr_d;
                        state_q  <= RELEASE;
                    end else if (tmo_cnt_q != '1) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    // One cycle for the winner to drop its level request.
                    ack_q   <= '0;
                    drop_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign br_req_o   = br_req_q;
    assign br_data_o  = br_data_q;
    assign ack_o      = ack_q;
    assign drop_o     = drop_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign sent_cnt_o = sent_cnt_q;

endmodule

// File: tb/tb_br_send_arbiter.sv
// Directed bench for br_send_arbiter: two instances (watchdog 8 and 4 cycles) on shared stimulus.
module tb_br_send_arbiter;

    typedef struct packed {
        logic [3:0]  ksvc;
        logic [11:0] src;
        logic [15:0] target;
        logic [31:0] payload;
    } br_payload_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req;
    logic [1:0][63:0]    data;
    logic                lbusy;
    logic                br_ack;

    logic [1:0]  a_ack, b_ack;
    logic        a_drop, b_drop;
    logic        a_grant, b_grant;
    logic        a_busy, b_busy;
    logic [31:0] a_sent, b_sent;
    logic        a_breq, b_breq;
    logic [63:0] a_bdata, b_bdata;
    br_payload_t a_pay;

    int n_cmp = 0;
    int n_err = 0;

    assign a_pay = a_bdata;

    always #5 clk = ~clk;

    br_send_arbiter #(.N_REQ(2), .ACK_TIMEOUT(8), .PAYLOAD_W(64)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data),
        .ack_o(a_ack), .drop_o(a_drop), .grant_o(a_grant), .busy_o(a_busy),
        .sent_cnt_o(a_sent), .br_local_busy_i(lbusy), .br_req_o(a_breq),
        .br_ack_i(br_ack), .br_data_o(a_bdata)
    );

    br_send_arbiter #(.N_REQ(2), .ACK_TIMEOUT(4), .PAYLOAD_W(64)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data),
        .ack_o(b_ack), .drop_o(b_drop), .grant_o(b_grant), .busy_o(b_busy),
        .sent_cnt_o(b_sent), .br_local_busy_i(lbusy), .br_req_o(b_breq),
        .br_ack_i(br_ack), .br_data_o(b_bdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; req = 2'b00; br_ack = 1'b0; lbusy = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++; if (a_breq !== 1'b0) begin n_err++; $display("FAIL reset_br_req: got %0b want 0", a_breq); end
        n_cmp++; if (a_bdata !== 64'd0) begin n_err++; $display("FAIL reset_br_data: got %0h want 0", a_bdata); end
        n_cmp++; if (a_ack !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %0b want 00", a_ack); end
        n_cmp++; if (a_drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %0b want 0", a_drop); end
        n_cmp++; if (a_grant !== 1'b0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", a_grant); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", a_busy); end
        n_cmp++; if (a_sent !== 32'd0) begin n_err++; $display("FAIL reset_sent: got %0d want 0", a_sent); end
    endtask

    task automatic test_single_send();
        int busy_cycles;
        reset_dut();
        data[0] = {4'h5, 12'h012, 16'h0101, 32'hCAFE_0001};
        data[1] = {4'hA, 12'h0FF, 16'h0202, 32'hBEEF_0002};
        req = 2'b01;
        busy_cycles = 0;
        tick();
        if (a_busy) busy_cycles++;
        n_cmp++; if (a_breq !== 1'b1) begin n_err++; $display("FAIL single_req_rise: got %0b want 1", a_breq); end
        n_cmp++; if (a_pay.ksvc !== 4'h5) begin n_err++; $display("FAIL single_ksvc: got %0h want 5", a_pay.ksvc); end
        n_cmp++; if (a_bdata !== data[0]) begin n_err++; $display("FAIL single_data: got %0h want %0h", a_bdata, data[0]); end
        tick(); if (a_busy) busy_cycles++;
        tick(); if (a_busy) busy_cycles++;
        n_cmp++; if (a_breq !== 1'b1) begin n_err++; $display("FAIL single_req_held: got %0b want 1", a_breq); end
        br_ack = 1'b1;
        tick(); if (a_busy) busy_cycles++;
        br_ack = 1'b0;
        n_cmp++; if (a_ack !== 2'b01) begin n_err++; $display("FAIL single_ack: got %0b want 01", a_ack); end
        n_cmp++; if (a_breq !== 1'b0) begin n_err++; $display("FAIL single_req_fall: got %0b want 0", a_breq); end
        n_cmp++; if (a_sent !== 32'd1) begin n_err++; $display("FAIL single_sent: got %0d want 1", a_sent); end
        n_cmp++; if (a_drop !== 1'b0) begin n_err++; $display("FAIL single_drop: got %0b want 0", a_drop); end
        req = 2'b00;
        tick(); if (a_busy) busy_cycles++;
        n_cmp++; if (a_ack !== 2'b00) begin n_err++; $display("FAIL single_ack_pulse: got %0b want 00", a_ack); end
        tick(); if (a_busy) busy_cycles++;
        n_cmp++; if (busy_cycles !== 4) begin n_err++; $display("FAIL single_busy_len: got %0d want 4", busy_cycles); end
    endtask

    task automatic test_fairness();
        int rise_t[4];
        int rise_g[4];
        int nr;
        logic prev;
        reset_dut();
        req = 2'b11; br_ack = 1'b1;
        nr = 0; prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_breq && !prev && nr < 4) begin
                rise_t[nr] = i; rise_g[nr] = int'(a_grant); nr++;
            end
            prev = a_breq;
        end
        n_cmp++; if (nr !== 4) begin n_err++; $display("FAIL fair_rises: got %0d want 4", nr); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= nr || rise_g[k] !== (k % 2)) begin
                n_err++; $display("FAIL fair_grant%0d: got %0d want %0d", k, (k < nr) ? rise_g[k] : -1, k % 2);
            end
        end
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (k >= nr || (rise_t[k] - rise_t[k-1]) !== 3) begin
                n_err++; $display("FAIL fair_spacing%0d: got %0d want 3", k, (k < nr) ? rise_t[k] - rise_t[k-1] : -1);
            end
        end
        n_cmp++; if (a_sent !== 32'd4) begin n_err++; $display("FAIL fair_sent: got %0d want 4", a_sent); end
        req = 2'b00; br_ack = 1'b0;
    endtask

    task automatic test_busy_gating();
        int hi;
        reset_dut();
        lbusy = 1'b1; req = 2'b10; hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_breq) hi++;
        end
        n_cmp++; if (hi !== 0) begin n_err++; $display("FAIL gate_held_off: got %0d high cycles want 0", hi); end
        lbusy = 1'b0;
        tick();
        n_cmp++; if (a_breq !== 1'b1) begin n_err++; $display("FAIL gate_rise: got %0b want 1", a_breq); end
        n_cmp++; if (a_grant !== 1'b1) begin n_err++; $display("FAIL gate_grant: got %0d want 1", a_grant); end
        br_ack = 1'b1;
        tick();
        br_ack = 1'b0;
        n_cmp++; if (a_ack !== 2'b10) begin n_err++; $display("FAIL gate_ack: got %0b want 10", a_ack); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        int hi;
        int guard;
        reset_dut();
        req = 2'b11;
        tick();
        n_cmp++; if (a_grant !== 1'b0) begin n_err++; $display("FAIL tmo_first_grant: got %0d want 0", a_grant); end
        hi = 0; guard = 0;
        while (a_breq && guard < 30) begin
            hi++; guard++;
            tick();
        end
        n_cmp++; if (hi !== 8) begin n_err++; $display("FAIL tmo_req_len: got %0d want 8", hi); end
        n_cmp++; if (a_ack !== 2'b01) begin n_err++; $display("FAIL tmo_ack: got %0b want 01", a_ack); end
        n_cmp++; if (a_drop !== 1'b1) begin n_err++; $display("FAIL tmo_drop: got %0b want 1", a_drop); end
        n_cmp++; if (a_sent !== 32'd0) begin n_err++; $display("FAIL tmo_sent: got %0d want 0", a_sent); end
        tick();
        n_cmp++; if (a_drop !== 1'b0) begin n_err++; $display("FAIL tmo_drop_pulse: got %0b want 0", a_drop); end
        tick();
        n_cmp++; if (a_breq !== 1'b1 || a_grant !== 1'b1) begin
            n_err++; $display("FAIL tmo_next_grant: got req %0b grant %0d want req 1 grant 1", a_breq, a_grant);
        end
        br_ack = 1'b1;
        tick();
        br_ack = 1'b0; req = 2'b00;
        n_cmp++; if (a_sent !== 32'd1 || a_drop !== 1'b0) begin
            n_err++; $display("FAIL tmo_then_ack: got sent %0d drop %0b want sent 1 drop 0", a_sent, a_drop);
        end
        tick();
    endtask

    task automatic test_ack_at_timeout();
        reset_dut();
        req = 2'b01;
        tick();
        tick(); tick(); tick();
        n_cmp++; if (b_breq !== 1'b1) begin n_err++; $display("FAIL edge_req_held: got %0b want 1", b_breq); end
        br_ack = 1'b1;
        tick();
        br_ack = 1'b0; req = 2'b00;
        n_cmp++; if (b_ack !== 2'b01) begin n_err++; $display("FAIL edge_ack: got %0b want 01", b_ack); end
        n_cmp++; if (b_drop !== 1'b0) begin n_err++; $display("FAIL edge_drop: got %0b want 0", b_drop); end
        n_cmp++; if (b_sent !== 32'd1) begin n_err++; $display("FAIL edge_sent: got %0d want 1", b_sent); end
        tick();
    endtask

    task automatic test_reset_mid_send();
        reset_dut();
        req = 2'b01;
        tick();
        br_ack = 1'b1;
        tick();
        br_ack = 1'b0; req = 2'b00;
        tick(); tick();
        req = 2'b11;
        tick();
        n_cmp++; if (a_grant !== 1'b1 || a_breq !== 1'b1) begin
            n_err++; $display("FAIL mid_pre_grant: got req %0b grant %0d want req 1 grant 1", a_breq, a_grant);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (a_breq !== 1'b0 || a_ack !== 2'b00 || a_busy !== 1'b0 || a_grant !== 1'b0 ||
                     a_sent !== 32'd0 || a_bdata !== 64'd0 || a_drop !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_vals: got req %0b ack %0b busy %0b grant %0d sent %0d data %0h drop %0b want all 0",
                              a_breq, a_ack, a_busy, a_grant, a_sent, a_bdata, a_drop);
        end
        tick();
        n_cmp++; if (a_breq !== 1'b1 || a_grant !== 1'b0) begin
            n_err++; $display("FAIL mid_regrant: got req %0b grant %0d want req 1 grant 0", a_breq, a_grant);
        end
        req = 2'b00;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; br_ack = 1'b0; lbusy = 1'b0;
        data[0] = '0; data[1] = '0;
        test_reset();
        test_single_send();
        test_fairness();
        test_busy_gating();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
